// File: rtl/frame_buf_arb_pkg.sv
// frame_buf_arb_pkg: arbiter state encodings, requester IDs and the idle-state grant decision.
package frame_buf_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR0  = 2'd1,
        ST_WR1  = 2'd2,
        ST_RD   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ID_CAM0 = 2'd0,
        ID_CAM1 = 2'd1,
        ID_DISP = 2'd2
    } req_id_t;

    // Display read always wins; writers only alternate when both are waiting.
    function automatic state_t next_grant(input logic disp, input logic c0, input logic c1,
                                          input logic rr);
        return disp ? ST_RD :
               (c0 & c1) ? (rr ? ST_WR1 : ST_WR0) :
               c0 ? ST_WR0 :
               c1 ? ST_WR1 : ST_IDLE;
    endfunction

endpackage

// File: rtl/frame_buf_arb_if.sv
// frame_buf_arb_if: requester and RAM-port signals around the frame buffer arbiter.
interface frame_buf_arb_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    logic              cam0_req;
    logic [ADDR_W-1:0] cam0_addr;
    logic [DATA_W-1:0] cam0_data;
    logic              cam0_ack;
    logic              cam1_req;
    logic [ADDR_W-1:0] cam1_addr;
    logic [DATA_W-1:0] cam1_data;
    logic              cam1_ack;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_ack;
    logic [DATA_W-1:0] disp_data;
    logic              disp_data_valid;
    logic              mem_wr_en;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr_rdy;
    logic              mem_rd_rdy;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_rd_data_valid;

    modport master (
        input  cam0_req, cam0_addr, cam0_data, cam1_req, cam1_addr, cam1_data,
               disp_req, disp_addr, mem_wr_rdy, mem_rd_rdy, mem_rd_data, mem_rd_data_valid,
        output cam0_ack, cam1_ack, disp_ack, disp_data, disp_data_valid,
               mem_wr_en, mem_rd_en, mem_wr_addr, mem_rd_addr, mem_wr_data
    );

    modport slave (
        output cam0_req, cam0_addr, cam0_data, cam1_req, cam1_addr, cam1_data,
               disp_req, disp_addr, mem_wr_rdy, mem_rd_rdy, mem_rd_data, mem_rd_data_valid,
        input  cam0_ack, cam1_ack, disp_ack, disp_data, disp_data_valid,
               mem_wr_en, mem_rd_en, mem_wr_addr, mem_rd_addr, mem_wr_data
    );
endinterface

// File: rtl/frame_buf_arb_stats.sv
// fb_arb_stats: free-running accepted-beat counters for cam0, cam1 and display reads.
module fb_arb_stats (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wr0,
    input  logic        i_wr1,
    input  logic        i_rd,
    output logic [31:0] o_wr0,
    output logic [31:0] o_wr1,
    output logic [31:0] o_rd
);
    always_ff @(posedge clk) begin
        if (!reset) begin
            o_wr0 <= '0;
            o_wr1 <= '0;
            o_rd  <= '0;
        end else begin
            o_wr0 <= o_wr0 + 32'(i_wr0);
            o_wr1 <= o_wr1 + 32'(i_wr1);
            o_rd  <= o_rd + 32'(i_rd);
        end
    end
endmodule

// File: rtl/frame_buf_arb.sv
// frame_buf_arb: burst arbiter sharing one RAM port between two camera writers and the display reader.
// Define FB_ARB_STATS_EN to add per-requester accepted-beat counters (stat_wr0/stat_wr1/stat_rd).
module frame_buf_arb
    import frame_buf_arb_pkg::*;
#(
    parameter int BURST_LEN = 16,
    parameter int MAX_OUTST = 8
) (
    input  logic            clk,
    input  logic            reset,
    frame_buf_arb_if.master bus
`ifdef FB_ARB_STATS_EN
    ,
    output logic [31:0]     stat_wr0,
    output logic [31:0]     stat_wr1,
    output logic [31:0]     stat_rd
`endif
);
    localparam int BC_W = $clog2(BURST_LEN + 1);
    localparam int OC_W = $clog2(MAX_OUTST + 1);

    state_t          r_state;
    logic            r_rr_ptr;
    logic [BC_W-1:0] r_beat_cnt;
    logic [OC_W-1:0] r_outst;

    logic w_wr0;
    logic w_wr1;
    logic w_rd;
    logic w_req;
    logic w_beat;
    logic w_last;

    // Enables are gated by reset so a beat in flight when reset drops is never acked.
    assign w_wr0  = reset & (r_state == ST_WR0) & bus.cam0_req & bus.mem_wr_rdy;
    assign w_wr1  = reset & (r_state == ST_WR1) & bus.cam1_req & bus.mem_wr_rdy;
    assign w_rd   = reset & (r_state == ST_RD) & bus.disp_req & bus.mem_rd_rdy
                  & (r_outst < OC_W'(MAX_OUTST));
    assign w_req  = (r_state == ST_WR0) ? bus.cam0_req :
                    (r_state == ST_WR1) ? bus.cam1_req :
                    (r_state == ST_RD)  ? bus.disp_req : 1'b0;
    assign w_beat = w_wr0 | w_wr1 | w_rd;
    assign w_last = w_beat & (r_beat_cnt == BC_W'(BURST_LEN - 1));

    assign bus.cam0_ack    = w_wr0;
    assign bus.cam1_ack    = w_wr1;
    assign bus.disp_ack    = w_rd;
    assign bus.mem_wr_en   = w_wr0 | w_wr1;
    assign bus.mem_rd_en   = w_rd;
    assign bus.mem_wr_addr = (r_state == ST_WR1) ? bus.cam1_addr : bus.cam0_addr;
    assign bus.mem_wr_data = (r_state == ST_WR1) ? bus.cam1_data : bus.cam0_data;
    assign bus.mem_rd_addr = bus.disp_addr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= 1'b0;
            r_beat_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_state <= next_grant(bus.disp_req, bus.cam0_req, bus.cam1_req, r_rr_ptr);
        end else if (w_last | ~w_req) begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= '0;
            r_rr_ptr   <= (r_state == ST_WR0) ? 1'b1 : (r_state == ST_WR1) ? 1'b0 : r_rr_ptr;
        end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end

    // Returns with nothing outstanding (stale after reset) still forward but do not count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_outst <= '0;
        end else if (w_rd & ~bus.mem_rd_data_valid) begin
            r_outst <= r_outst + 1'b1;
        end else if (~w_rd & bus.mem_rd_data_valid & (r_outst != '0)) begin
            r_outst <= r_outst - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.disp_data       <= '0;
            bus.disp_data_valid <= 1'b0;
        end else begin
            bus.disp_data       <= bus.mem_rd_data;
            bus.disp_data_valid <= bus.mem_rd_data_valid;
        end
    end

`ifdef FB_ARB_STATS_EN
    fb_arb_stats u_stats (
        .clk   (clk),
        .reset (reset),
        .i_wr0 (w_wr0),
        .i_wr1 (w_wr1),
        .i_rd  (w_rd),
        .o_wr0 (stat_wr0),
        .o_wr1 (stat_wr1),
        .o_rd  (stat_rd)
    );
`endif

endmodule

// File: tb/tb_frame_buf_arb.sv
// tb_frame_buf_arb: directed bursts against a per-cycle grant/outstanding model plus literal burst checks.
module tb_frame_buf_arb;
    localparam int BL = 16;
    localparam int MO = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    frame_buf_arb_if #(.ADDR_W(24), .DATA_W(32)) bus();
`ifdef FB_ARB_STATS_EN
    logic [31:0] stat_wr0, stat_wr1, stat_rd;
`endif

    frame_buf_arb #(.BURST_LEN(BL), .MAX_OUTST(MO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FB_ARB_STATS_EN
        ,
        .stat_wr0 (stat_wr0),
        .stat_wr1 (stat_wr1),
        .stat_rd  (stat_rd)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: grant owner (-1 none, 0 cam0, 1 cam1, 2 display), beats in burst, next writer, reads in flight.
    int g = -1, beats = 0, rr = 0, outst = 0;
    logic [31:0] e_dd = '0;
    logic e_dv = 1'b0;
    int unsigned s0 = 0, s1 = 0, sr = 0;

    always @(negedge clk) begin : model
        logic e0, e1, er, req_g;
        e0 = reset && g == 0 && bus.cam0_req && bus.mem_wr_rdy;
        e1 = reset && g == 1 && bus.cam1_req && bus.mem_wr_rdy;
        er = reset && g == 2 && bus.disp_req && bus.mem_rd_rdy && outst < MO;
        chk("cam0_ack", bus.cam0_ack, e0);
        chk("cam1_ack", bus.cam1_ack, e1);
        chk("disp_ack", bus.disp_ack, er);
        chk("mem_wr_en", bus.mem_wr_en, e0 | e1);
        chk("mem_rd_en", bus.mem_rd_en, er);
        chk("disp_data", bus.disp_data, e_dd);
        chk("disp_data_valid", bus.disp_data_valid, e_dv);
        if (e0 | e1) begin
            chk("mem_wr_addr", bus.mem_wr_addr, e0 ? bus.cam0_addr : bus.cam1_addr);
            chk("mem_wr_data", bus.mem_wr_data, e0 ? bus.cam0_data : bus.cam1_data);
        end
        if (er) chk("mem_rd_addr", bus.mem_rd_addr, bus.disp_addr);
`ifdef FB_ARB_STATS_EN
        chk("stat_wr0", stat_wr0, s0);
        chk("stat_wr1", stat_wr1, s1);
        chk("stat_rd", stat_rd, sr);
`endif
        if (!reset) begin
            g = -1; beats = 0; rr = 0; outst = 0; e_dd = '0; e_dv = 1'b0;
            s0 = 0; s1 = 0; sr = 0;
        end else begin
            e_dd = bus.mem_rd_data;
            e_dv = bus.mem_rd_data_valid;
            if (er && !bus.mem_rd_data_valid) outst++;
            else if (!er && bus.mem_rd_data_valid && outst > 0) outst--;
            s0 += 32'(e0); s1 += 32'(e1); sr += 32'(er);
            if (g < 0) begin
                g = bus.disp_req ? 2 : (bus.cam0_req && bus.cam1_req) ? rr :
                    bus.cam0_req ? 0 : bus.cam1_req ? 1 : -1;
            end else begin
                req_g = g == 0 ? bus.cam0_req : g == 1 ? bus.cam1_req : bus.disp_req;
                if (e0 | e1 | er) beats++;
                if (!req_g || beats == BL) begin
                    if (g < 2) rr = 1 - g;
                    g = -1;
                    beats = 0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        bus.cam0_addr   = 24'($urandom);
        bus.cam0_data   = $urandom;
        bus.cam1_addr   = 24'($urandom);
        bus.cam1_data   = $urandom;
        bus.disp_addr   = 24'($urandom);
        bus.mem_rd_data = $urandom;
    end

    function automatic logic ackv(input int w);
        return w == 0 ? bus.cam0_ack : w == 1 ? bus.cam1_ack : bus.disp_ack;
    endfunction

    task automatic wait_ack(input int w, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = ackv(w);
        end
        if (!ok) chk("ack_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_len(input int w, output int n);
        bit ok;
        bit run;
        n = 0;
        wait_ack(w, ok);
        if (ok) begin
            n = 1;
            run = 1'b1;
            for (int i = 0; i < 200 && run; i++) begin
                @(negedge clk);
                if (ackv(w)) n++;
                else run = 1'b0;
            end
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        bit ok;
        logic [31:0] x;
        bus.cam0_req = 1'b0; bus.cam1_req = 1'b0; bus.disp_req = 1'b0;
        bus.mem_wr_rdy = 1'b1; bus.mem_rd_rdy = 1'b1; bus.mem_rd_data_valid = 1'b0;
        bus.cam0_addr = '0; bus.cam0_data = '0; bus.cam1_addr = '0; bus.cam1_data = '0;
        bus.disp_addr = '0; bus.mem_rd_data = '0;
        tick(3);
        @(negedge clk);
        chk("rst_wr_en", bus.mem_wr_en, 1'b0);
        chk("rst_rd_en", bus.mem_rd_en, 1'b0);
        chk("rst_disp_valid", bus.disp_data_valid, 1'b0);
        chk("rst_disp_data", bus.disp_data, 32'd0);
        tick(1);
        reset = 1'b1;
        bus.cam0_req = 1'b1;
        run_len(0, n);
        chk("t1_burst_len", n, 16);
        @(negedge clk);
        chk("t1_regrant", bus.cam0_ack, 1'b1);
        tick(1);
        bus.cam0_req = 1'b0;
        tick(1);
        bus.cam0_req = 1'b1;
        bus.cam1_req = 1'b1;
        run_len(1, n);
        chk("t2_wr1_burst", n, 16);
        run_len(0, n);
        chk("t2_wr0_burst", n, 16);
        run_len(1, n);
        chk("t2_wr1_again", n, 16);
        tick(1);
        bus.cam0_req = 1'b0;
        bus.cam1_req = 1'b0;
        tick(3);
        bus.cam0_req = 1'b1;
        fork
            run_len(0, n);
            begin
                tick(6);
                bus.disp_req = 1'b1;
                bus.cam1_req = 1'b1;
            end
        join
        chk("t3_wr0_finishes", n, 16);
        bus.cam0_req = 1'b0;
        @(negedge clk);
        chk("t3_rd_before_wr1", bus.disp_ack, 1'b1);
        run_len(2, n);
        chk("t4_outst_cap", n + 1, 8);
        n = 0;
        repeat (3) begin
            @(negedge clk);
            n += int'(bus.disp_ack);
        end
        chk("t4_stalled", n, 0);
        tick(1);
        bus.mem_rd_data_valid = 1'b1;
        @(negedge clk);
        x = bus.mem_rd_data;
        tick(1);
        bus.mem_rd_data_valid = 1'b0;
        @(negedge clk);
        chk("t4_ret_valid", bus.disp_data_valid, 1'b1);
        chk("t4_ret_data", bus.disp_data, x);
        chk("t4_one_more_ack", bus.disp_ack, 1'b1);
        n = 0;
        repeat (4) begin
            @(negedge clk);
            n += int'(bus.disp_ack);
        end
        chk("t4_restalled", n, 0);
        tick(1);
        bus.disp_req = 1'b0;
        run_len(1, n);
        chk("t4_wr1_after_rd", n, 16);
        tick(1);
        bus.cam1_req = 1'b0;
        tick(3);
        bus.cam0_req = 1'b1;
        wait_ack(0, ok);
        fork
            begin
                tick(4);
                bus.mem_wr_rdy = 1'b0;
                tick(3);
                bus.mem_wr_rdy = 1'b1;
            end
            begin
                n = 1;
                repeat (18) begin
                    @(negedge clk);
                    n += int'(bus.cam0_ack);
                end
            end
        join
        chk("t5_beats_kept", n, 16);
        @(negedge clk);
        chk("t5_burst_end", bus.cam0_ack, 1'b0);
        tick(1);
        bus.cam0_req = 1'b0;
        tick(3);
        bus.cam1_req = 1'b1;
        wait_ack(1, ok);
        tick(4);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_beat5_not_acked", bus.cam1_ack, 1'b0);
        @(negedge clk);
        chk("t6_wr_en", bus.mem_wr_en, 1'b0);
        chk("t6_ack", bus.cam1_ack, 1'b0);
        chk("t6_disp_valid", bus.disp_data_valid, 1'b0);
        chk("t6_disp_data", bus.disp_data, 32'd0);
`ifdef FB_ARB_STATS_EN
        chk("t6_stat_wr1", stat_wr1, 32'd0);
`endif
        tick(1);
        reset = 1'b1;
        run_len(1, n);
        chk("t6_fresh_burst", n, 16);
        tick(1);
        bus.cam1_req = 1'b0;
        tick(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
